// File: rtl/pmic_rail_sequencer.sv
// ============================================================================
// pmic_rail_sequencer : ordered LDO power-up/power-down with PG checks and faults
// Rev 1.0
// ============================================================================
`default_nettype none

module pmic_rail_sequencer #(
  parameter int N_RAILS = 3,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       on_req,
  input  logic                       low_bat,
  input  logic                       low_pow,
  input  logic [N_RAILS-1:0]         rail_pg,
  input  logic [N_RAILS*CNT_W-1:0]   dly_cfg,
  output logic [N_RAILS-1:0]         rail_en,
  output logic                       ready,
  output logic                       fault,
  output logic [1:0]                 fault_code,
  output logic [2:0]                 state_o
);

  localparam int IDX_W = (N_RAILS > 2) ? $clog2(N_RAILS) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_RAILS - 1);

  localparam logic [1:0] C_CODE_NONE    = 2'b00;
  localparam logic [1:0] C_CODE_PG_TO   = 2'b01;
  localparam logic [1:0] C_CODE_PG_LOST = 2'b10;
  localparam logic [1:0] C_CODE_LOW_POW = 2'b11;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_PWRUP = 3'd1,
    S_ON    = 3'd2,
    S_PWRDN = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [N_RAILS-1:0]     r_rail_en, w_rail_en_nxt;
  logic                   r_ready, w_ready_nxt;
  logic                   r_fault, w_fault_nxt;
  logic [1:0]             r_fault_code, w_fault_code_nxt;

  logic [IDX_W-1:0]       w_idx_inc;
  logic [IDX_W-1:0]       w_idx_dec;

  assign w_idx_inc = r_idx + IDX_W'(1);
  assign w_idx_dec = r_idx - IDX_W'(1);

  function automatic logic [CNT_W-1:0] f_dly(input logic [IDX_W-1:0] idx);
    return dly_cfg[int'(idx)*CNT_W +: CNT_W];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_OFF;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_rail_en    <= '0;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= C_CODE_NONE;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rail_en    <= w_rail_en_nxt;
      r_ready      <= w_ready_nxt;
      r_fault      <= w_fault_nxt;
      r_fault_code <= w_fault_code_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_cnt_nxt        = r_cnt;
    w_rail_en_nxt    = r_rail_en;
    w_ready_nxt      = r_ready;
    w_fault_nxt      = r_fault;
    w_fault_code_nxt = r_fault_code;

    case (r_state)
      S_OFF: begin
        if (on_req && !low_bat && !low_pow) begin
          w_state_nxt      = S_PWRUP;
          w_idx_nxt        = '0;
          w_cnt_nxt        = f_dly('0);
          w_rail_en_nxt    = '0;
          w_rail_en_nxt[0] = 1'b1;
        end
      end

      S_PWRUP: begin
        if (low_pow) begin
          w_state_nxt      = S_FAULT;
          w_rail_en_nxt    = '0;
          w_ready_nxt      = 1'b0;
          w_fault_nxt      = 1'b1;
          w_fault_code_nxt = C_CODE_LOW_POW;
          w_idx_nxt        = '0;
          w_cnt_nxt        = '0;
        end else if (!on_req || low_bat) begin
          // Abort: unwind from the rail currently being brought up.
          w_state_nxt = S_PWRDN;
          w_cnt_nxt   = f_dly(r_idx);
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (rail_pg[r_idx]) begin
          if (r_idx == C_LAST_IDX) begin
            w_state_nxt = S_ON;
            w_ready_nxt = 1'b1;
          end else begin
            w_idx_nxt                = w_idx_inc;
            w_rail_en_nxt[w_idx_inc] = 1'b1;
            w_cnt_nxt                = f_dly(w_idx_inc);
          end
        end else begin
          w_state_nxt      = S_FAULT;
          w_rail_en_nxt    = '0;
          w_ready_nxt      = 1'b0;
          w_fault_nxt      = 1'b1;
          w_fault_code_nxt = C_CODE_PG_TO;
          w_idx_nxt        = '0;
          w_cnt_nxt        = '0;
        end
      end

      S_ON: begin
        w_rail_en_nxt = '1;
        w_ready_nxt   = 1'b1;
        if (low_pow || !(&rail_pg)) begin
          w_state_nxt      = S_FAULT;
          w_rail_en_nxt    = '0;
          w_ready_nxt      = 1'b0;
          w_fault_nxt      = 1'b1;
          w_fault_code_nxt = low_pow ? C_CODE_LOW_POW : C_CODE_PG_LOST;
          w_idx_nxt        = '0;
          w_cnt_nxt        = '0;
        end else if (!on_req || low_bat) begin
          w_state_nxt = S_PWRDN;
          w_ready_nxt = 1'b0;
          w_idx_nxt   = C_LAST_IDX;
          w_cnt_nxt   = f_dly(C_LAST_IDX);
        end
      end

      S_PWRDN: begin
        if (low_pow) begin
          w_state_nxt      = S_FAULT;
          w_rail_en_nxt    = '0;
          w_ready_nxt      = 1'b0;
          w_fault_nxt      = 1'b1;
          w_fault_code_nxt = C_CODE_LOW_POW;
          w_idx_nxt        = '0;
          w_cnt_nxt        = '0;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_rail_en_nxt[r_idx] = 1'b0;
          if (r_idx == '0) begin
            w_state_nxt = S_OFF;
            w_cnt_nxt   = '0;
          end else begin
            w_idx_nxt = w_idx_dec;
            w_cnt_nxt = f_dly(w_idx_dec);
          end
        end
      end

      S_FAULT: begin
        w_rail_en_nxt = '0;
        w_ready_nxt   = 1'b0;
        w_fault_nxt   = 1'b1;
        if (!on_req) begin
          w_state_nxt      = S_OFF;
          w_fault_nxt      = 1'b0;
          w_fault_code_nxt = C_CODE_NONE;
          w_idx_nxt        = '0;
          w_cnt_nxt        = '0;
        end
      end

      default: begin
        w_state_nxt      = S_OFF;
        w_idx_nxt        = '0;
        w_cnt_nxt        = '0;
        w_rail_en_nxt    = '0;
        w_ready_nxt      = 1'b0;
        w_fault_nxt      = 1'b0;
        w_fault_code_nxt = C_CODE_NONE;
      end
    endcase
  end

  assign rail_en    = r_rail_en;
  assign ready      = r_ready;
  assign fault      = r_fault;
  assign fault_code = r_fault_code;
  assign state_o    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pmic_rail_sequencer.sv
// ============================================================================
// tb_pmic_rail_sequencer : directed scenarios with a cycle-tagged scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pmic_rail_sequencer;

  localparam int N_RAILS = 3;
  localparam int CNT_W   = 16;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     on_req;
  logic                     low_bat;
  logic                     low_pow;
  logic [N_RAILS-1:0]       rail_pg;
  logic [N_RAILS*CNT_W-1:0] dly_cfg;
  logic [N_RAILS-1:0]       rail_en;
  logic                     ready;
  logic                     fault;
  logic [1:0]               fault_code;
  logic [2:0]               state_o;

  pmic_rail_sequencer #(.N_RAILS(N_RAILS), .CNT_W(CNT_W)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .on_req     (on_req),
    .low_bat    (low_bat),
    .low_pow    (low_pow),
    .rail_pg    (rail_pg),
    .dly_cfg    (dly_cfg),
    .rail_en    (rail_en),
    .ready      (ready),
    .fault      (fault),
    .fault_code (fault_code),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  // LDO model: PG follows enable one cycle later; pg_kill forces bits low.
  logic [N_RAILS-1:0] pg_d    = '0;
  logic [N_RAILS-1:0] pg_kill = '0;
  always @(posedge clk) pg_d <= rail_en;
  assign rail_pg = pg_d & ~pg_kill;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] en;
    logic       rdy;
    logic       flt;
    logic [1:0] code;
    logic [2:0] st;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic expect_at(input int c, input logic [2:0] en, input logic rdy,
                           input logic flt, input logic [1:0] code,
                           input logic [2:0] st, input string nm);
    exp_t e;
    e.cyc = c; e.en = en; e.rdy = rdy; e.flt = flt; e.code = code; e.st = st; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares the DUT outputs at the cycle each expectation is tagged with.
  exp_t m_e;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      n_checks++;
      if (m_e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", m_e.nm, m_e.cyc, cyc);
      end else if ({rail_en, ready, fault, fault_code, state_o} !==
                   {m_e.en, m_e.rdy, m_e.flt, m_e.code, m_e.st}) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got en=%b rdy=%b flt=%b code=%b st=%0d, want en=%b rdy=%b flt=%b code=%b st=%0d",
                 m_e.nm, cyc, rail_en, ready, fault, fault_code, state_o,
                 m_e.en, m_e.rdy, m_e.flt, m_e.code, m_e.st);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int c0, x0, f0, k0, l0, r0;

  initial begin
    reset   = 1'b1;
    on_req  = 1'b0;
    low_bat = 1'b0;
    low_pow = 1'b0;
    dly_cfg = {16'd3, 16'd2, 16'd4};

    // Reset state
    wait_cyc(2);
    expect_at(2, 3'b000, 0, 0, 2'b00, 3'd0, "reset_state");
    reset = 1'b0;
    expect_at(3, 3'b000, 0, 0, 2'b00, 3'd0, "off_idle");

    // low_bat blocks power-up
    wait_cyc(4);
    on_req = 1'b1; low_bat = 1'b1; c0 = cyc;
    expect_at(c0 + 1, 3'b000, 0, 0, 2'b00, 3'd0, "lowbat_off_1");
    expect_at(c0 + 3, 3'b000, 0, 0, 2'b00, 3'd0, "lowbat_off_3");

    // Normal power-up
    wait_cyc(c0 + 3);
    low_bat = 1'b0; c0 = cyc;
    expect_at(c0 + 1,  3'b001, 0, 0, 2'b00, 3'd1, "up_rail0");
    expect_at(c0 + 5,  3'b001, 0, 0, 2'b00, 3'd1, "up_rail0_hold");
    expect_at(c0 + 6,  3'b011, 0, 0, 2'b00, 3'd1, "up_rail1");
    expect_at(c0 + 9,  3'b111, 0, 0, 2'b00, 3'd1, "up_rail2");
    expect_at(c0 + 12, 3'b111, 0, 0, 2'b00, 3'd1, "up_not_ready");
    expect_at(c0 + 13, 3'b111, 1, 0, 2'b00, 3'd2, "up_ready");

    // Normal power-down
    wait_cyc(c0 + 15);
    on_req = 1'b0; x0 = cyc;
    expect_at(x0 + 1,  3'b111, 0, 0, 2'b00, 3'd3, "dn_start");
    expect_at(x0 + 4,  3'b111, 0, 0, 2'b00, 3'd3, "dn_hold2");
    expect_at(x0 + 5,  3'b011, 0, 0, 2'b00, 3'd3, "dn_rail2");
    expect_at(x0 + 8,  3'b001, 0, 0, 2'b00, 3'd3, "dn_rail1");
    expect_at(x0 + 12, 3'b001, 0, 0, 2'b00, 3'd3, "dn_hold0");
    expect_at(x0 + 13, 3'b000, 0, 0, 2'b00, 3'd0, "dn_off");

    // PG timeout on rail 1
    wait_cyc(x0 + 15);
    pg_kill = 3'b010; on_req = 1'b1; c0 = cyc;
    expect_at(c0 + 8,  3'b011, 0, 0, 2'b00, 3'd1, "pgto_wait");
    expect_at(c0 + 9,  3'b000, 0, 1, 2'b01, 3'd4, "pgto_fault");
    expect_at(c0 + 12, 3'b000, 0, 1, 2'b01, 3'd4, "pgto_hold");
    wait_cyc(c0 + 12);
    on_req = 1'b0; pg_kill = 3'b000; f0 = cyc;
    expect_at(f0 + 1, 3'b000, 0, 0, 2'b00, 3'd0, "pgto_clear");

    // PG lost while ON
    wait_cyc(f0 + 3);
    on_req = 1'b1; c0 = cyc;
    wait_cyc(c0 + 15);
    pg_kill = 3'b100; k0 = cyc;
    expect_at(k0,     3'b111, 1, 0, 2'b00, 3'd2, "pglost_on");
    expect_at(k0 + 1, 3'b000, 0, 1, 2'b10, 3'd4, "pglost_fault");
    wait_cyc(k0 + 1);
    pg_kill = 3'b000;
    wait_cyc(k0 + 2);
    on_req = 1'b0;
    expect_at(k0 + 3, 3'b000, 0, 0, 2'b00, 3'd0, "pglost_clear");

    // low_pow during power-down
    wait_cyc(k0 + 4);
    on_req = 1'b1; c0 = cyc;
    wait_cyc(c0 + 15);
    on_req = 1'b0; x0 = cyc;
    wait_cyc(x0 + 3);
    low_pow = 1'b1; l0 = cyc;
    expect_at(l0,     3'b111, 0, 0, 2'b00, 3'd3, "lowpow_pwrdn");
    expect_at(l0 + 1, 3'b000, 0, 1, 2'b11, 3'd4, "lowpow_fault");
    wait_cyc(l0 + 1);
    low_pow = 1'b0;
    expect_at(l0 + 2, 3'b000, 0, 0, 2'b00, 3'd0, "lowpow_clear");

    // low_bat abort mid power-up at rail 1
    wait_cyc(l0 + 4);
    on_req = 1'b1; c0 = cyc;
    expect_at(c0 + 6,  3'b011, 0, 0, 2'b00, 3'd1, "abort_rail1");
    expect_at(c0 + 8,  3'b011, 0, 0, 2'b00, 3'd3, "abort_pwrdn");
    expect_at(c0 + 10, 3'b011, 0, 0, 2'b00, 3'd3, "abort_no_rail2");
    expect_at(c0 + 11, 3'b001, 0, 0, 2'b00, 3'd3, "abort_rail1_off");
    expect_at(c0 + 16, 3'b000, 0, 0, 2'b00, 3'd0, "abort_off");
    wait_cyc(c0 + 7);
    low_bat = 1'b1;
    wait_cyc(c0 + 18);
    low_bat = 1'b0; on_req = 1'b0;

    // Reset mid power-up with simultaneous low_pow
    wait_cyc(c0 + 20);
    on_req = 1'b1; c0 = cyc;
    wait_cyc(c0 + 7);
    reset = 1'b1; low_pow = 1'b1; r0 = cyc;
    expect_at(r0,     3'b011, 0, 0, 2'b00, 3'd1, "rst_pre");
    expect_at(r0 + 1, 3'b000, 0, 0, 2'b00, 3'd0, "rst_clear");
    wait_cyc(r0 + 1);
    reset = 1'b0; low_pow = 1'b0; on_req = 1'b0;
    expect_at(r0 + 3, 3'b000, 0, 0, 2'b00, 3'd0, "rst_stay_off");

    wait_cyc(r0 + 6);
    if (q.size() != 0) begin
      n_checks += q.size();
      n_fail   += q.size();
      $display("FAIL scoreboard: %0d expectations never compared", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pmic_rail_sequencer.md
Name: pmic_rail_sequencer

Overview:
Parametrised power-rail sequencer for the PMIC. It powers N_RAILS LDO enables up in ascending order and down in reverse order. Each step has a run-time programmable delay and power-good (PG) confirmation. Battery and power monitors trigger orderly shutdown or emergency fault shutdown. The block sits between the board-level ON/OFF and monitor inputs and the LDO enable pins, and generalises the fixed three-rail sequencer by adding PG checking, abort and fault reporting.

Parameters:
N_RAILS, 3, number of sequenced rails (2..8); rail 0 is first up and last down.
CNT_W, 16, width of each per-rail delay field and of the internal down-counter.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
on_req  in  1  1 = request power-up/stay on, 0 = request power-down
low_bat  in  1  battery low: blocks power-up; triggers orderly power-down when on
low_pow  in  1  input power collapse: triggers emergency fault shutdown
rail_pg  in  N_RAILS  per-rail power-good from the LDOs
dly_cfg  in  N_RAILS*CNT_W  per-rail delay; field i is bits [i*CNT_W +: CNT_W]; sampled when step i starts
rail_en  out  N_RAILS  LDO enables, registered
ready  out  1  all rails up and confirmed, registered
fault  out  1  sticky fault flag, registered
fault_code  out  2  00 none, 01 PG timeout, 10 PG lost while ON, 11 low_pow
state_o  out  3  encoded state: 0 OFF, 1 PWRUP, 2 ON, 3 PWRDN, 4 FAULT

Behaviour:
- Reset (synchronous, highest priority, any state, including mid-sequence): state OFF; rail_en=0, ready=0, fault=0, fault_code=00, idx=0, cnt=0.
- All outputs are registered. A decision made in cycle t is visible in cycle t+1.
- OFF:
  - If on_req=1 and low_bat=0 and low_pow=0: go to PWRUP with idx=0, rail_en[0]=1, cnt=dly_cfg[0].
  - Otherwise stay in OFF.
- PWRUP, evaluated each cycle in this priority order:
  - low_pow=1: go to FAULT, code 11.
  - on_req=0 or low_bat=1: abort to PWRDN starting at the current idx. The rails already enabled stay on until their reverse step.
  - cnt!=0: decrement cnt.
  - cnt==0 and rail_pg[idx]=1:
    - if idx==N_RAILS-1: go to ON, ready=1.
    - else: idx++, rail_en[idx+1]=1, cnt=dly_cfg[idx+1].
  - cnt==0 and rail_pg[idx]=0: go to FAULT, code 01.
  - Net effect: rail i is enabled for dly_cfg[i]+1 cycles before its PG check. A delay of 0 means the check happens on the next cycle.
- ON:
  - rail_en all 1, ready=1.
  - Priority order: low_pow (FAULT, 11) > any rail_pg bit 0 (FAULT, 10) > on_req=0 or low_bat=1 (PWRDN).
  - Entering PWRDN: ready=0 in the same transition, idx=N_RAILS-1, cnt=dly_cfg[N_RAILS-1].
- PWRDN:
  - low_pow=1: go to FAULT, code 11.
  - cnt!=0: decrement cnt.
  - cnt==0:
    - clear rail_en[idx].
    - if idx==0: go to OFF.
    - else: idx--, cnt=dly_cfg[idx-1].
  - on_req returning to 1 during PWRDN is ignored. The sequence completes to OFF and re-evaluates there.
  - PG is not checked in PWRDN.
- FAULT:
  - rail_en=0 and ready=0 in the entry transition (all rails off at once). fault=1.
  - Stay in FAULT while on_req=1.
  - On the first cycle with on_req=0: go to OFF, clearing fault and fault_code.
- Simultaneous events: the priority is as listed per state. Reset beats everything.
- Counter never wraps: decrement only when non-zero.
- Unused state encodings go to OFF with all outputs cleared.

Test Plan:
- N=3, dly={4,2,3}, PG tied to rail_en delayed 1 cycle, on_req 0→1 at t0 → rail_en 001 at t1, 011 at t6, 111 at t9, ready=1 at t13, state_o=2.
- From ON, on_req→0 at tx → ready=0 at tx+1; rail_en 011 after 4 more cycles (dly[2]+1), then 001 after 3, then 000 after 5; state_o=0.
- PWRUP with rail_pg[1] stuck 0, dly[1]=2 → FAULT 3 cycles after rail_en[1] rises; rail_en=000, fault=1, code=01; hold while on_req=1; on_req=0 → OFF, fault=0 next cycle.
- In ON, force rail_pg[2]=0 for 1 cycle → next cycle rail_en=000, code=10. Separately, low_pow=1 in PWRDN → code=11.
- low_bat=1 with on_req=1 in OFF → stays OFF, rail_en=000. Then low_bat=1 mid-PWRUP at idx=1 → reverse shutdown from rail 1, rail 2 never enabled.
- Reset asserted mid-PWRUP with rail_en=011 → next cycle all outputs 0, state_o=0. A simultaneous low_pow does not set fault.
